// File: rtl/x1_cond_pkg.sv
// Shared definitions for the x1 input conditioner.
// Step-mode encodings and the debounce state set.
package x1_cond_pkg;

    localparam logic [1:0] MODE_RUN    = 2'b00;
    localparam logic [1:0] MODE_DIV    = 2'b01;
    localparam logic [1:0] MODE_SINGLE = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } db_state_e;

endpackage

// File: rtl/x1_input_conditioner_debounce_cell.sv
// Synchronizer, debounce FSM and edge pulses for one async pin.
// The output flips only after DB_LIMIT consecutive differing samples.
module debounce_cell
    import x1_cond_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_LIMIT    = 10,
    parameter int DB_CNT_W    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam logic [DB_CNT_W-1:0] LIM_M1 = DB_CNT_W'(DB_LIMIT - 1);
    localparam logic [DB_CNT_W-1:0] ONE    = DB_CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   smp;

    db_state_e              state_q;
    db_state_e              state_d;
    logic [DB_CNT_W-1:0]    cnt_q;
    logic [DB_CNT_W-1:0]    cnt_d;
    logic                   clean_q;
    logic                   clean_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], raw};
    assign smp    = sync_q[SYNC_STAGES-1];

    // Next-state logic: qualify a level change over DB_LIMIT samples.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            STABLE_LO: begin
                if (smp) begin
                    if (DB_LIMIT == 1) begin
                        clean_d = 1'b1;
                        rise_d  = 1'b1;
                        state_d = STABLE_HI;
                        cnt_d   = '0;
                    end else begin
                        state_d = PEND_HI;
                        cnt_d   = ONE;
                    end
                end
            end
            PEND_HI: begin
                if (!smp) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == LIM_M1) begin
                    clean_d = 1'b1;
                    rise_d  = 1'b1;
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            STABLE_HI: begin
                if (!smp) begin
                    if (DB_LIMIT == 1) begin
                        clean_d = 1'b0;
                        fall_d  = 1'b1;
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                    end else begin
                        state_d = PEND_LO;
                        cnt_d   = ONE;
                    end
                end
            end
            PEND_LO: begin
                if (smp) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == LIM_M1) begin
                    clean_d = 1'b0;
                    fall_d  = 1'b1;
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    // Synchronizer chain, FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean = clean_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/x1_input_conditioner.sv
// Front end for the Moore machine: clean x1 plus the step strobe.
// Holds the mode synchronizer, the step divider and step_en.
module x1_input_conditioner
    import x1_cond_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_LIMIT    = 10,
    parameter int DB_CNT_W    = 4,
    parameter int STEP_DIV    = 1000,
    parameter int DIV_W       = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       x_raw,
    input  logic       step_btn_raw,
    input  logic [1:0] mode_raw,
    output logic       x_clean,
    output logic       x_rise,
    output logic       x_fall,
    output logic       step_en,
    output logic [1:0] mode_q
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic             btn_rise;
    logic             btn_clean_unused;
    logic             btn_fall_unused;

    logic [1:0]       mode_s1_q;
    logic [1:0]       mode_prev_q;
    logic [1:0]       vld_q;
    logic             mode_ok;
    logic             mode_chg;
    logic             run_ok;

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             step_en_q;
    logic             step_en_d;

    debounce_cell #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_LIMIT    (DB_LIMIT),
        .DB_CNT_W    (DB_CNT_W)
    ) u_x_db (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (x_raw),
        .clean (x_clean),
        .rise  (x_rise),
        .fall  (x_fall)
    );

    debounce_cell #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_LIMIT    (DB_LIMIT),
        .DB_CNT_W    (DB_CNT_W)
    ) u_btn_db (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (step_btn_raw),
        .clean (btn_clean_unused),
        .rise  (btn_rise),
        .fall  (btn_fall_unused)
    );

    // mode_q only reflects real pin samples once the chain has filled.
    assign mode_ok  = vld_q[1];
    assign mode_chg = (mode_q != mode_prev_q);
    assign run_ok   = ena && mode_ok && !mode_chg;

    // Step strobe and divider; any mode change or ena=0 clears both.
    always_comb begin
        div_d     = '0;
        step_en_d = 1'b0;
        unique case (1'b1)
            (mode_q == MODE_RUN): begin
                step_en_d = run_ok;
            end
            (mode_q == MODE_DIV): begin
                if (run_ok) begin
                    div_d     = (div_q == DIV_LAST) ? '0 : div_q + DIV_ONE;
                    step_en_d = (div_q == DIV_LAST);
                end
            end
            (mode_q == MODE_SINGLE): begin
                step_en_d = run_ok && btn_rise;
            end
            (mode_q == MODE_HOLD): begin
                step_en_d = 1'b0;
            end
            default: begin
                step_en_d = 1'b0;
            end
        endcase
    end

    // Mode synchronizer, change tracking, divider and strobe flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_s1_q   <= 2'b00;
            mode_q      <= 2'b00;
            mode_prev_q <= 2'b00;
            vld_q       <= 2'b00;
            div_q       <= '0;
            step_en_q   <= 1'b0;
        end else begin
            mode_s1_q   <= mode_raw;
            mode_q      <= mode_s1_q;
            mode_prev_q <= mode_q;
            vld_q       <= {vld_q[0], 1'b1};
            div_q       <= div_d;
            step_en_q   <= step_en_d;
        end
    end

    assign step_en = step_en_q;

endmodule

// File: tb/tb_x1_input_conditioner.sv
// Self-checking bench for x1_input_conditioner.
// Table of per-cycle vectors plus directed multi-cycle sequences.
module tb_x1_input_conditioner;

    localparam int SYNC_STAGES = 2;
    localparam int DB_LIMIT    = 4;
    localparam int DB_CNT_W    = 4;
    localparam int STEP_DIV    = 5;
    localparam int DIV_W       = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       x_raw;
    logic       step_btn_raw;
    logic [1:0] mode_raw;
    logic       x_clean;
    logic       x_rise;
    logic       x_fall;
    logic       step_en;
    logic [1:0] mode_q;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       x;
        logic       en;
        logic       c;
        logic       r;
        logic       f;
        logic       s;
        logic [1:0] m;
    } vec_t;

    vec_t tbl[$];

    x1_input_conditioner #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_LIMIT    (DB_LIMIT),
        .DB_CNT_W    (DB_CNT_W),
        .STEP_DIV    (STEP_DIV),
        .DIV_W       (DIV_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .x_raw        (x_raw),
        .step_btn_raw (step_btn_raw),
        .mode_raw     (mode_raw),
        .x_clean      (x_clean),
        .x_rise       (x_rise),
        .x_fall       (x_fall),
        .step_en      (step_en),
        .mode_q       (mode_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add(input int n, input logic x, input logic en,
                       input logic c, input logic r, input logic f);
        vec_t v;
        v.x  = x;
        v.en = en;
        v.c  = c;
        v.r  = r;
        v.f  = f;
        v.s  = en;
        v.m  = 2'b00;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic wait_step(output int n, input int lim);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!step_en && n < lim);
    endtask

    task automatic count_steps(input int cycles, output int k);
        k = 0;
        for (int i = 0; i < cycles; i++) begin
            cyc();
            if (step_en) k++;
        end
    endtask

    initial begin
        int n;
        int k;
        int kk;

        add(5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        add(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        add(5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add(7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        add(3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        rst_n        = 1'b0;
        ena          = 1'b1;
        x_raw        = 1'b0;
        step_btn_raw = 1'b0;
        mode_raw     = 2'b00;

        repeat (3) cyc();
        chk("rst_x_clean", x_clean, 0);
        chk("rst_x_rise", x_rise, 0);
        chk("rst_x_fall", x_fall, 0);
        chk("rst_step_en", step_en, 0);
        chk("rst_mode_q", mode_q, 0);

        rst_n = 1'b1;
        cyc();
        chk("idle_step_c1", step_en, 0);
        cyc();
        chk("idle_step_c2", step_en, 0);
        cyc();
        chk("idle_step_c3", step_en, 1);
        chk("idle_mode_q", mode_q, 0);
        chk("idle_x_clean", x_clean, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            x_raw = tbl[i].x;
            ena   = tbl[i].en;
            cyc();
            chk($sformatf("vec%0d_clean", i), x_clean, tbl[i].c);
            chk($sformatf("vec%0d_rise", i), x_rise, tbl[i].r);
            chk($sformatf("vec%0d_fall", i), x_fall, tbl[i].f);
            chk($sformatf("vec%0d_step", i), step_en, tbl[i].s);
            chk($sformatf("vec%0d_mode", i), mode_q, tbl[i].m);
        end

        mode_raw = 2'b01;
        cyc();
        cyc();
        chk("div_mode_q", mode_q, 1);
        cyc();
        chk("div_chg_step", step_en, 0);
        wait_step(n, 20);
        chk("div_first_gap", n, 5);
        for (int j = 0; j < 3; j++) begin
            wait_step(n, 20);
            chk($sformatf("div_gap%0d", j), n, 5);
        end

        cyc();
        cyc();
        ena = 1'b0;
        count_steps(7, k);
        chk("div_ena0_steps", k, 0);
        ena = 1'b1;
        wait_step(n, 20);
        chk("div_ena_back_gap", n, 5);

        mode_raw = 2'b10;
        count_steps(6, k);
        chk("single_mode_q", mode_q, 2);
        chk("single_idle_steps", k, 0);

        step_btn_raw = 1'b1;
        n = 0;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (step_en) begin
                k++;
                if (n == 0) n = i;
            end
        end
        step_btn_raw = 1'b0;
        count_steps(15, kk);
        chk("single_hold_steps", k + kk, 1);
        chk("single_latency", n, 7);

        k = 0;
        for (int j = 0; j < 3; j++) begin
            step_btn_raw = 1'b1;
            count_steps(1, kk);
            k += kk;
            step_btn_raw = 1'b0;
            count_steps(2, kk);
            k += kk;
            step_btn_raw = 1'b1;
            count_steps(2, kk);
            k += kk;
            step_btn_raw = 1'b0;
            count_steps(3, kk);
            k += kk;
        end
        count_steps(10, kk);
        chk("single_bounce_steps", k + kk, 0);

        step_btn_raw = 1'b1;
        count_steps(10, k);
        step_btn_raw = 1'b0;
        count_steps(10, kk);
        chk("single_second_press", k + kk, 1);

        mode_raw = 2'b11;
        count_steps(4, k);
        chk("hold_mode_q", mode_q, 3);
        count_steps(8, k);
        chk("hold_steps", k, 0);

        mode_raw = 2'b00;
        repeat (5) cyc();
        chk("run_again_step", step_en, 1);

        x_raw = 1'b1;
        repeat (4) cyc();
        chk("mid_pend_clean", x_clean, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_step", step_en, 0);
        chk("mid_rst_clean", x_clean, 0);
        @(negedge clk);
        cyc();
        rst_n = 1'b1;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!x_clean && n < 20);
        chk("mid_requal_lat", n, 6);
        chk("mid_requal_rise", x_rise, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/x1_input_conditioner.md
Name: x1_input_conditioner

Overview:
- Front-end stage that feeds the Moore machine's x1 input and its advance enable.
- Synchronizes and debounces the raw x1 pin and a raw step-button pin, then generates clean edge pulses.
- Produces a one-cycle step strobe used as the Moore machine's clock enable: every cycle, divided rate, single-step, or hold.
- Sits between the ui_in pins and the Moore machine inside the tt_um_ top.

Parameters:
- SYNC_STAGES, 2, synchronizer flops per async input (minimum 2).
- DB_LIMIT, 10, consecutive differing synchronized samples required to flip a debounced output (minimum 1).
- DB_CNT_W, 4, debounce counter width; must satisfy 2^DB_CNT_W > DB_LIMIT.
- STEP_DIV, 1000, clock cycles per step tick in divided mode (minimum 2).
- DIV_W, 10, divider width; must satisfy 2^DIV_W >= STEP_DIV.

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  asynchronous, active-low reset; all flops clear immediately on assertion.
- ena  in  1  Tiny Tapeout enable; 0 forces step_en=0 and clears the divider.
- x_raw  in  1  asynchronous x1 pin (ui_in[0]).
- step_btn_raw  in  1  asynchronous single-step button (ui_in[1]).
- mode_raw  in  2  quasi-static step mode pins (ui_in[3:2]).
- x_clean  out  1  debounced x1, fed to the Moore machine x1.
- x_rise  out  1  one-cycle pulse; asserted in the same cycle x_clean first reads 1.
- x_fall  out  1  one-cycle pulse; asserted in the same cycle x_clean first reads 0.
- step_en  out  1  registered one-cycle advance strobe for the Moore machine.
- mode_q  out  2  synchronized mode, for status display.

Behaviour:
- Reset values: x_clean=0, x_rise=0, x_fall=0, step_en=0, mode_q=00. All synchronizer flops, counters and the divider are 0. Debounce FSMs are in STABLE_LO.
- Synchronizer: SYNC_STAGES-deep flop chain per input. mode_raw uses a 2-flop chain per bit.
- Debounce FSM per input (states STABLE_LO, PEND_HI, STABLE_HI, PEND_LO):
  - STABLE_x: if the synchronized value differs from the output, go to PEND_* with cnt=1.
  - PEND_*: if the sample still differs and cnt==DB_LIMIT-1, flip the output, clear cnt, go to the opposite STABLE. If it still differs otherwise, cnt++.
  - PEND_*: if the sample equals the output, return to STABLE with cnt=0. The output does not change.
  - DB_LIMIT=1: the output flips on the first differing sample.
- Latency: x_raw changes and is held, and edge 1 is the first edge that samples it. x_clean changes after edge SYNC_STAGES+DB_LIMIT.
- Glitch rejection: any pulse shorter than DB_LIMIT cycles after synchronization produces no output change.
- x_rise / x_fall are registered and coincide with the x_clean transition. They are never both 1.
- Step modes, decoded from mode_q:
  - 00 RUN: step_en=1 every cycle while ena=1.
  - 01 DIV: divider counts 0..STEP_DIV-1 and wraps to 0. step_en=1 for the one cycle after the divider equals STEP_DIV-1. Rate is exactly one strobe per STEP_DIV cycles.
  - 10 SINGLE: step_en=1 for exactly one cycle per debounced step-button rise. A held button gives one strobe; the release gives none.
  - 11 HOLD: step_en=0.
- Mode change: in any cycle where mode_q differs from its previous value:
  - step_en=0 in the following cycle.
  - the divider clears to 0.
  - a button rise coincident with the mode change is discarded.
- Divider: runs only in DIV with ena=1. In all other cases it is held at 0.
- ena=0: step_en=0 and the divider is cleared. Synchronizers and debouncers keep running, so x_clean remains valid.
- Reset mid-operation: everything returns to reset values immediately. After release, a held-high x_raw re-qualifies with full latency.

Decomposition:
- Shared package x1_cond_pkg:
  - step-mode encodings: MODE_RUN=2'b00, MODE_DIV=2'b01, MODE_SINGLE=2'b10, MODE_HOLD=2'b11.
  - debounce state enum: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
- Sub-module debounce_cell (synchronizer + debounce FSM + rise/fall pulse).
  - Instantiated twice: for x_raw and for step_btn_raw.
  - Top level holds the mode synchronizer, divider and step_en logic.

Test Plan:
Bench uses SYNC_STAGES=2, DB_LIMIT=4, STEP_DIV=5.
1. Reset then idle: rst_n low for 3 cycles, then high, all inputs 0 -> all outputs 0, mode_q=00; step_en=1 from cycle 3 after release (mode-sync latency).
2. Clean edge: x_raw 0->1 held -> x_clean=1 and x_rise=1 after exactly 6 edges; x_rise lasts 1 cycle. Return to 0 -> x_fall after 6 edges.
3. Glitch: x_raw high for 3 cycles then low -> x_clean stays 0, no pulses. A 4-cycle pulse produces a flip.
4. DIV mode: mode_raw=01 held -> step_en pulses spaced exactly 5 cycles apart. Drop ena for 7 cycles -> no pulses; the first pulse comes 5 cycles after ena returns.
5. SINGLE mode: button held 20 cycles -> exactly one step_en pulse. Button bounces 1-2 cycle pulses -> none. A second clean press gives one more pulse.
6. Reset mid-debounce: assert rst_n during PEND_HI (cycle 4 of 6) -> x_clean=0 immediately. After release with x_raw still 1, x_clean rises 6 edges later.
